// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding an 8N1 UART transmitter. Console bytes arrive as single-cycle
// strobes at core rate and leave LSB-first on tx at CLKS_PER_BIT clocks per bit.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 2170,
  parameter int FIFO_DEPTH   = 16,
  parameter int CW           = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [7:0]    in_byte,
  input  logic          in_byte_en,
  input  logic          overflow_clr,
  output logic          tx,
  output logic          tx_busy,
  output logic [CW-1:0] fifo_count,
  output logic          fifo_full,
  output logic          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_d;
  logic [BW-1:0] baud_cnt, baud_d;
  logic [2:0]    bit_idx, bit_d;
  logic [7:0]    shift, shift_d;
  logic          tx_d;
  logic          busy_d;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_d;
  logic          pop, push, drop, baud_wrap;

  assign fifo_full = (fifo_count == DEPTH_C);
  assign pop       = (state == IDLE) && (fifo_count != '0);
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign push      = in_byte_en && (!fifo_full || pop);
  assign drop      = in_byte_en && !push;
  assign baud_wrap = (baud_cnt == BAUD_LAST);

  always_comb begin
    count_d = fifo_count;
    if (push && !pop)
      count_d = fifo_count + CW'(1);
    else if (pop && !push)
      count_d = fifo_count - CW'(1);
  end

  always_comb begin
    state_d = state;
    baud_d  = baud_cnt;
    bit_d   = bit_idx;
    shift_d = shift;
    case (state)
      IDLE: begin
        if (pop) begin
          state_d = START;
          baud_d  = '0;
          shift_d = mem[rd_ptr];
        end
      end
      START: begin
        if (baud_wrap) begin
          state_d = DATA;
          baud_d  = '0;
          bit_d   = '0;
        end else begin
          baud_d = baud_cnt + BW'(1);
        end
      end
      DATA: begin
        if (baud_wrap) begin
          baud_d  = '0;
          shift_d = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7)
            state_d = STOP;
          else
            bit_d = bit_idx + 3'd1;
        end else begin
          baud_d = baud_cnt + BW'(1);
        end
      end
      STOP: begin
        if (baud_wrap) begin
          state_d = IDLE;
          baud_d  = '0;
        end else begin
          baud_d = baud_cnt + BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // tx and tx_busy are decoded from the next state so they register in step with it.
  always_comb begin
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE) || (count_d != '0);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      tx         <= 1'b1;
      tx_busy    <= 1'b0;
    end else begin
      state      <= state_d;
      baud_cnt   <= baud_d;
      bit_idx    <= bit_d;
      fifo_count <= count_d;
      tx         <= tx_d;
      tx_busy    <= busy_d;
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (drop)
        overflow <= 1'b1;
      else if (overflow_clr)
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    shift <= shift_d;
    if (push)
      mem[wr_ptr] <= in_byte;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Downstream consumer of the SoC's memory-mapped byte output (out_byte / out_byte_en strobe from the core's 0x1000_0000 write path).
- Buffers bytes in a small FIFO and serialises them as 8N1 UART frames on a single tx pin, so firmware console output reaches a host terminal.
- Absorbs single-cycle write bursts at the core clock rate. Reports fill level, busy and a sticky overflow flag.

Parameters:
- CLKS_PER_BIT, 2170, clock cycles per UART bit (250 MHz / 115200 baud); legal range 2 and up.
- FIFO_DEPTH, 16, FIFO entries; power of two, 2 and up.
- CW, $clog2(FIFO_DEPTH)+1, width of fifo_count (derived; do not override).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- resetn  input  1  asynchronous active-low reset.
- in_byte  input  8  byte to transmit, sampled when in_byte_en=1.
- in_byte_en  input  1  single-cycle write strobe; may be asserted every cycle.
- overflow_clr  input  1  clears overflow (synchronous).
- tx  output  1  UART serial out, idle high.
- tx_busy  output  1  1 while a frame is in flight or the FIFO is non-empty.
- fifo_count  output  CW  entries currently held, 0..FIFO_DEPTH.
- fifo_full  output  1  fifo_count == FIFO_DEPTH.
- overflow  output  1  sticky: a byte was dropped.

Behaviour:
- Reset (async, resetn=0): tx=1, tx_busy=0, fifo_count=0, fifo_full=0, overflow=0, FSM=IDLE, pointers=0, baud and bit counters=0.
- Reset mid-frame: tx returns high immediately. FIFO contents and the partial frame are discarded; no resume after release.
- Push:
  - A push occurs when in_byte_en=1 and (fifo_full=0 or a pop occurs in the same cycle).
  - Otherwise the byte is dropped and overflow is set on the next edge.
  - Simultaneous push and pop: count unchanged, both take effect.
  - Pointers wrap modulo FIFO_DEPTH.
- Overflow: set has priority over overflow_clr in the same cycle. Dropped bytes never corrupt stored data.
- Pop: occurs only in IDLE with fifo_count>0. The head byte is loaded into the shift register, the FSM moves to START, and the baud counter is cleared.
- FSM states:
  - IDLE: tx=1. Moves to START on pop.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: tx = shift[0] for CLKS_PER_BIT cycles per bit, LSB first. Shift right after each bit. After bit 7 moves to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps. A state/bit advance happens on the wrap cycle.
- Latency: in_byte_en high in cycle 0 with FSM idle and FIFO empty -> count=1 in cycle 1, pop in cycle 1 -> tx low from cycle 2.
  - Frame length is exactly 10*CLKS_PER_BIT cycles.
  - Back-to-back frames pass through one IDLE cycle, so the start-to-start period is 10*CLKS_PER_BIT+1 cycles.
- tx is a registered output, glitch-free.
- tx_busy = (state != IDLE) or (fifo_count != 0), registered consistently with state/count.
- fifo_full and fifo_count reflect the post-edge state.

Test Plan:
- Single byte, CLKS_PER_BIT=4: in_byte=0x55 strobed in cycle 0.
  - Required: tx low in cycles 2-5; data bits 1,0,1,0,1,0,1,0 at 4 cycles each; stop high in cycles 38-41.
  - tx_busy falls after cycle 41; fifo_count returns to 0 in cycle 2.
- Burst, FIFO_DEPTH=4: in_byte_en high in cycles 0-5 with bytes 0x01..0x06.
  - Required: 0x01..0x05 accepted; 0x06 dropped; overflow=1 from cycle 6.
  - Frames carry 0x01..0x05 in order, start bits 10*CLKS_PER_BIT+1 cycles apart.
- Full plus pop: fill the FIFO during a frame, then strobe 0xA5 exactly in the IDLE pop cycle.
  - Required: 0xA5 accepted; count stays FIFO_DEPTH; overflow stays 0.
  - 0xA5 is transmitted last.
- Overflow clear: overflow=1, then assert overflow_clr with no drop.
  - Required: overflow=0 next cycle.
  - Assert overflow_clr in the same cycle as a dropped push: overflow stays 1.
- Reset mid-frame: resetn=0 during DATA bit 3.
  - Required: tx=1 asynchronously; count=0, busy=0, overflow=0.
  - After release with no push, tx stays 1 for 100 cycles.
- Wrap-around: push 3*FIFO_DEPTH bytes, paced at one per frame.
  - Required: all bytes received in order with no loss; overflow=0.
